// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter and burst sequencer between fetch (I) and load/store (D) ports and mainMem
module mem_port_arbiter #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [0:ADDR_W-1] i_addr,
  input  logic [1:0]        i_acc_size,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wren,
  input  logic [0:ADDR_W-1] d_addr,
  input  logic [1:0]        d_acc_size,
  input  logic [31:0]       d_wdata,
  output logic              d_wack,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              mem_enable,
  output logic              mem_wren,
  output logic [0:ADDR_W-1] mem_addr,
  output logic [1:0]        mem_acc_size,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  input  logic              mem_busy
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

  // The command cycle itself is the first RD_WAIT cycle, hence RD_LAT-1 further wait cycles.
  localparam logic [7:0] LAT_M1 = 8'(RD_LAT - 1);

  function automatic logic [3:0] beats_m1(input logic [1:0] size);
    case (size)
      2'b00:   return 4'd0;
      2'b01:   return 4'd3;
      2'b10:   return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  state_t            r_state;
  logic              r_own_d;
  logic              r_last_d;
  logic              r_enable;
  logic              r_wren;
  logic [0:ADDR_W-1] r_addr;
  logic [1:0]        r_size;
  logic [3:0]        r_beat;
  logic [7:0]        r_wait;

  logic w_grant_i;
  logic w_grant_d;
  logic w_wr_beat;
  logic w_rd_beat;
  logic w_last;

  // On a tie the port that did not win last time gets the memory.
  assign w_grant_i = i_req && (!d_req || r_last_d);
  assign w_grant_d = d_req && (!i_req || !r_last_d);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_own_d  <= 1'b0;
      r_last_d <= 1'b1;
      r_enable <= 1'b0;
      r_wren   <= 1'b0;
      r_addr   <= '0;
      r_size   <= '0;
      r_beat   <= '0;
      r_wait   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!mem_busy && (w_grant_i || w_grant_d)) begin
            r_own_d  <= w_grant_d;
            r_last_d <= w_grant_d;
            r_enable <= 1'b1;
            r_wren   <= w_grant_d && d_wren;
            r_addr   <= w_grant_d ? {d_addr[0:ADDR_W-3], 2'b00} : {i_addr[0:ADDR_W-3], 2'b00};
            r_size   <= w_grant_d ? d_acc_size : i_acc_size;
            r_beat   <= beats_m1(w_grant_d ? d_acc_size : i_acc_size);
            r_wait   <= LAT_M1;
            r_state  <= (w_grant_d && d_wren) ? WR_BURST : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (r_wait == 8'd0) r_state <= RD_BURST;
          else r_wait <= r_wait - 8'd1;
        end
        WR_BURST, RD_BURST: begin
          if (r_beat == 4'd0) begin
            r_state  <= IDLE;
            r_enable <= 1'b0;
            r_wren   <= 1'b0;
            r_addr   <= '0;
            r_size   <= '0;
          end else begin
            r_beat <= r_beat - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Beat strobes decode registered state only; data lanes pass straight through while a beat is live.
  assign w_wr_beat = (r_state == WR_BURST);
  assign w_rd_beat = (r_state == RD_BURST);
  assign w_last    = (r_beat == 4'd0);

  assign mem_enable   = r_enable;
  assign mem_wren     = r_wren;
  assign mem_addr     = r_addr;
  assign mem_acc_size = r_size;
  assign mem_data_in  = w_wr_beat ? d_wdata : 32'd0;

  assign i_rvalid = w_rd_beat && !r_own_d;
  assign d_rvalid = w_rd_beat && r_own_d;
  assign d_wack   = w_wr_beat;
  assign i_rdata  = i_rvalid ? mem_data_out : 32'd0;
  assign d_rdata  = d_rvalid ? mem_data_out : 32'd0;
  assign i_done   = i_rvalid && w_last;
  assign d_done   = (d_rvalid || d_wack) && w_last;

endmodule
